// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent prescaled down-counters, one-shot or periodic,
// with sticky expiry flags and a channel-select count readback.
// Optional build macro MULTI_TIMER_IRQ_EN adds irq_mask input and registered timer_irq.

// One timer channel: IDLE/RUN control FSM plus count/prescale datapath.
module multi_timer_ch #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             stop,
    input  logic             clr,
    input  logic [CNT_W-1:0] load_val,
    input  logic [PRE_W-1:0] load_pre,
    input  logic             load_per,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             flag
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;

    st_t              st, st_nxt;
    logic [CNT_W-1:0] reload;
    logic [PRE_W-1:0] pre_cnt, pre_val;
    logic             periodic;
    logic             load_nz, tick, expire;

    assign running = (st == RUN);
    assign load_nz = load && (load_val != '0);
    assign tick    = running && (pre_cnt == pre_val);
    assign expire  = tick && (count == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else      st <= st_nxt;
    end

    // Next state: load beats stop, stop beats a tick/expiry.
    always_comb begin
        st_nxt = st;
        if (load)                    st_nxt = load_nz ? RUN : IDLE;
        else if (stop)               st_nxt = IDLE;
        else if (expire && !periodic) st_nxt = IDLE;
    end

    // Count, reload and prescaler datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            reload   <= '0;
            pre_cnt  <= '0;
            pre_val  <= '0;
            periodic <= 1'b0;
        end else if (load) begin
            pre_cnt <= '0;
            if (load_nz) begin
                count    <= load_val;
                reload   <= load_val;
                pre_val  <= load_pre;
                periodic <= load_per;
            end else begin
                count <= '0;
            end
        end else if (!stop && running) begin
            if (tick) begin
                pre_cnt <= '0;
                if (expire)              count <= periodic ? reload : '0;
                else if (count != '0)    count <= count - CNT_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    // Sticky flag: a real expiry wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          flag <= 1'b0;
        else if (expire && !load && !stop) flag <= 1'b1;
        else if (clr)                      flag <= 1'b0;
    end
endmodule

// Top: decodes set_ch onto the channel array and muxes the readback count.
module multi_timer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_timer,
    input  logic [CH_W-1:0]   set_ch,
    input  logic [CNT_W-1:0]  timer_set_val,
    input  logic [PRE_W-1:0]  set_prescale,
    input  logic              set_periodic,
    input  logic              stop_timer,
    input  logic [NUM_CH-1:0] clr_flag,
    input  logic [CH_W-1:0]   rd_ch,
`ifdef MULTI_TIMER_IRQ_EN
    input  logic [NUM_CH-1:0] irq_mask,
    output logic              timer_irq,
`endif
    output logic [NUM_CH-1:0] timer_is_high,
    output logic [NUM_CH-1:0] timer_running,
    output logic [CNT_W-1:0]  rd_cnt
);
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Out-of-range set_ch never matches any channel, so writes fall away.
        logic hit;
        assign hit = (set_ch == CH_W'(g));

        multi_timer_ch #(.CNT_W(CNT_W), .PRE_W(PRE_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .load     (set_timer && hit),
            .stop     (stop_timer && hit),
            .clr      (clr_flag[g]),
            .load_val (timer_set_val),
            .load_pre (set_prescale),
            .load_per (set_periodic),
            .count    (cnt[g]),
            .running  (timer_running[g]),
            .flag     (timer_is_high[g])
        );
    end

    // Readback mux; unmatched (out-of-range) selects read 0.
    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (rd_ch == CH_W'(i)) rd_cnt = cnt[i];
    end

`ifdef MULTI_TIMER_IRQ_EN
    // Registered interrupt: one cycle behind the enabled flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_irq <= 1'b0;
        else      timer_irq <= |(timer_is_high & irq_mask);
    end
`endif
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: expected values are queued on a scoreboard
// as stimulus is applied and popped against DUT outputs.
module tb_multi_timer;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int PRE_W  = 8;
    localparam int CH_W   = 3;   // one spare bit so set_ch/rd_ch can go out of range

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              set_timer = 1'b0;
    logic [CH_W-1:0]   set_ch = '0;
    logic [CNT_W-1:0]  timer_set_val = '0;
    logic [PRE_W-1:0]  set_prescale = '0;
    logic              set_periodic = 1'b0;
    logic              stop_timer = 1'b0;
    logic [NUM_CH-1:0] clr_flag = '0;
    logic [CH_W-1:0]   rd_ch = '0;
    logic [NUM_CH-1:0] timer_is_high;
    logic [NUM_CH-1:0] timer_running;
    logic [CNT_W-1:0]  rd_cnt;
`ifdef MULTI_TIMER_IRQ_EN
    logic [NUM_CH-1:0] irq_mask = '0;
    logic              timer_irq;
`endif

    multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .CH_W(CH_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .set_timer     (set_timer),
        .set_ch        (set_ch),
        .timer_set_val (timer_set_val),
        .set_prescale  (set_prescale),
        .set_periodic  (set_periodic),
        .stop_timer    (stop_timer),
        .clr_flag      (clr_flag),
        .rd_ch         (rd_ch),
`ifdef MULTI_TIMER_IRQ_EN
        .irq_mask      (irq_mask),
        .timer_irq     (timer_irq),
`endif
        .timer_is_high (timer_is_high),
        .timer_running (timer_running),
        .rd_cnt        (rd_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    int fail_cnt = 0;
    logic [31:0] sb_q[$];

    task automatic sb_push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        total++;
        if (sb_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL %s: observed %0h, nothing expected on scoreboard", tag, obs);
            return;
        end
        exp = sb_q.pop_front();
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(exp);
        sb_check(tag, obs);
    endtask

    // Advance one rising edge and land just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        set_timer  = 1'b0;
        stop_timer = 1'b0;
        clr_flag   = '0;
    endtask

    task automatic set_load(input int ch, input logic [31:0] n, input int p, input bit per);
        set_timer     = 1'b1;
        set_ch        = CH_W'(ch);
        timer_set_val = n;
        set_prescale  = PRE_W'(p);
        set_periodic  = per;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nv[4];
        logic [3:0] ef, er;
        nv = '{8, 5, 3, 6};

        // Reset
        idle_in();
        repeat (2) step();
        chk("rst_flag", 32'(timer_is_high), 0);
        chk("rst_run",  32'(timer_running), 0);
        chk("rst_rd",   rd_cnt, 0);
`ifdef MULTI_TIMER_IRQ_EN
        chk("rst_irq",  32'(timer_irq), 0);
`endif
        rst = 1'b1;
        step();

        // One-shot ch0, N=5 P=0
        set_load(0, 5, 0, 0);
        rd_ch = 0;
        step();
        idle_in();
        chk("os_cnt0", rd_cnt, 5);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("os_cnt",  rd_cnt, 32'(5 - k));
            chk("os_flag", 32'(timer_is_high[0]), 32'(k == 5));
            chk("os_run",  32'(timer_running[0]), 32'(k != 5));
        end
        clr_flag = 4'b0001;
        step();
        idle_in();
        chk("os_clr", 32'(timer_is_high[0]), 0);

        // Periodic ch1, N=3 P=1, clear at edge 8
        set_load(1, 3, 1, 1);
        rd_ch = 1;
        step();
        idle_in();
        chk("per_cnt0", rd_cnt, 3);
        for (int e = 1; e <= 12; e++) begin
            clr_flag = (e == 8) ? 4'b0010 : 4'b0000;
            step();
            chk("per_cnt",  rd_cnt, 32'(3 - ((e / 2) % 3)));
            chk("per_flag", 32'(timer_is_high[1]), 32'(((e >= 6) && (e < 8)) || (e >= 12)));
        end
        idle_in();
        stop_timer = 1'b1;
        set_ch     = 1;
        step();
        idle_in();
        chk("per_stop_run", 32'(timer_running[1]), 0);
        chk("per_stop_cnt", rd_cnt, 3);
        clr_flag = 4'b0010;
        step();
        idle_in();
        chk("per_clr", 32'(timer_is_high[1]), 0);

        // Collisions on ch2
        set_load(2, 2, 0, 0);
        rd_ch = 2;
        step();
        idle_in();
        step();
        chk("col_cnt1", rd_cnt, 1);
        set_load(2, 10, 0, 0);          // reload on the expiry edge
        step();
        idle_in();
        chk("col_noflag", 32'(timer_is_high[2]), 0);
        chk("col_cnt",    rd_cnt, 10);
        chk("col_run",    32'(timer_running[2]), 1);
        repeat (9) step();
        chk("col_cnt_pre", rd_cnt, 1);
        chk("col_flag_pre", 32'(timer_is_high[2]), 0);
        clr_flag = 4'b0100;             // clear on the expiry edge
        step();
        idle_in();
        chk("col_setclr", 32'(timer_is_high[2]), 1);
        chk("col_idle",   32'(timer_running[2]), 0);
        clr_flag = 4'b0100;
        step();
        idle_in();
        chk("col_clr", 32'(timer_is_high[2]), 0);

        // Stop and restart ch3
        set_load(3, 10, 0, 0);
        rd_ch = 3;
        step();
        idle_in();
        repeat (6) step();
        stop_timer = 1'b1;
        set_ch     = 3;
        step();
        idle_in();
        chk("stop_cnt", rd_cnt, 4);
        chk("stop_run", 32'(timer_running[3]), 0);
        repeat (20) step();
        chk("stop_hold", rd_cnt, 4);
        chk("stop_flag", 32'(timer_is_high[3]), 0);
        set_load(3, 2, 0, 0);
        step();
        idle_in();
        chk("rst_cnt", rd_cnt, 2);
        step();
        chk("rst_flag1", 32'(timer_is_high[3]), 0);
        step();
        chk("rst_flag2", 32'(timer_is_high[3]), 1);
        chk("rst_cnt2",  rd_cnt, 0);
        clr_flag = 4'b1000;
        step();
        idle_in();

        // N=0 loads, idle channel and running channel
        set_load(0, 0, 0, 0);
        rd_ch = 0;
        step();
        idle_in();
        chk("n0_run", 32'(timer_running[0]), 0);
        chk("n0_cnt", rd_cnt, 0);
        set_load(0, 9, 0, 0);
        step();
        set_load(0, 0, 0, 0);
        step();
        idle_in();
        chk("n0r_run", 32'(timer_running[0]), 0);
        chk("n0r_cnt", rd_cnt, 0);
        repeat (10) step();
        chk("n0_flag", 32'(timer_is_high[0]), 0);

        // Out-of-range set_ch / rd_ch
        set_load(4, 7, 0, 0);
        step();
        idle_in();
        chk("oor_run", 32'(timer_running), 0);
        rd_ch = 1;
        #1;
        chk("oor_rd1", rd_cnt, 3);
        rd_ch = 4;
        #1;
        chk("oor_rd4", rd_cnt, 0);
        repeat (8) step();
        chk("oor_flag", 32'(timer_is_high), 0);

        // Maximum load value
        set_load(0, 32'hffff_ffff, 0, 0);
        rd_ch = 0;
        step();
        idle_in();
        chk("max_cnt", rd_cnt, 32'hffff_ffff);
        repeat (3) step();
        chk("max_dec", rd_cnt, 32'hffff_fffc);

        // Asynchronous reset mid-count with a flag set
        set_load(1, 1, 0, 0);
        step();
        idle_in();
        step();
        chk("ar_pre_flag", 32'(timer_is_high[1]), 1);
        rst = 1'b0;
        #1;
        chk("ar_flag", 32'(timer_is_high), 0);
        chk("ar_run",  32'(timer_running), 0);
        chk("ar_rd",   rd_cnt, 0);
        step();
        rst = 1'b1;
        step();

        // All channels concurrently, staggered loads
        for (int e = 0; e <= 11; e++) begin
            idle_in();
            if (e < 4) set_load(e, 32'(nv[e]), 0, 0);
            step();
            for (int c = 0; c < 4; c++) begin
                ef[c] = (e >= c + nv[c]);
                er[c] = (e >= c) && (e < c + nv[c]);
            end
            sb_push(32'(ef));
            sb_push(32'(er));
            sb_check("all_flag", 32'(timer_is_high));
            sb_check("all_run",  32'(timer_running));
        end
        idle_in();
        clr_flag = 4'b1111;
        step();
        idle_in();
        chk("all_clr", 32'(timer_is_high), 0);

`ifdef MULTI_TIMER_IRQ_EN
        // IRQ masking: only ch1 enabled
        chk("irq_idle", 32'(timer_irq), 0);
        irq_mask = 4'b0010;
        set_load(0, 2, 0, 0);
        step();
        set_load(1, 3, 0, 0);
        step();
        idle_in();
        step();
        chk("irq_f0",    32'(timer_is_high[0]), 1);
        chk("irq_m0",    32'(timer_irq), 0);
        step();
        chk("irq_m0b",   32'(timer_irq), 0);
        step();
        chk("irq_f1",    32'(timer_is_high[1]), 1);
        chk("irq_lag",   32'(timer_irq), 0);
        step();
        chk("irq_rise",  32'(timer_irq), 1);
        clr_flag = 4'b0010;
        step();
        idle_in();
        chk("irq_clr_f", 32'(timer_is_high[1]), 0);
        chk("irq_hold",  32'(timer_irq), 1);
        step();
        chk("irq_fall",  32'(timer_irq), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel successor to `digitalTimer`, instantiated beside `mmu`, which drives its load/stop/clear strobes from memory-mapped writes. It provides `NUM_CH` independent down-counters, each with its own prescaler. Each channel runs in one-shot or periodic mode and raises a sticky expiry flag on `timer_is_high[ch]`. Current counts are readable through a channel-select mux.

## Interface
- `NUM_CH`, default 4: number of channels, 1..16.
- `CNT_W`, default 32: counter and load-value width.
- `PRE_W`, default 8: prescaler width.
- `CH_W`, default `$clog2(NUM_CH)` (minimum 1): channel index width.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `set_timer`  in  1  load strobe for channel `set_ch`.
- `set_ch`  in  CH_W  target channel for `set_timer`/`stop_timer`.
- `timer_set_val`  in  CNT_W  load value N.
- `set_prescale`  in  PRE_W  prescale P, latched on load.
- `set_periodic`  in  1  1 = periodic, 0 = one-shot; latched on load.
- `stop_timer`  in  1  halt channel `set_ch`.
- `clr_flag`  in  NUM_CH  per-channel flag clear, one-hot or multi-hot.
- `rd_ch`  in  CH_W  readback channel select.
- `timer_is_high`  out  NUM_CH  sticky expiry flags.
- `timer_running`  out  NUM_CH  channel active.
- `rd_cnt`  out  CNT_W  current count of channel `rd_ch`, combinational from registers.
- `timer_irq`  out  1  present only with `MULTI_TIMER_IRQ_EN`.

## Operation
- **Per-channel state:**
  - count[CNT_W], reload[CNT_W], pre_cnt[PRE_W], pre_val[PRE_W], periodic, running, flag.
- **Reset:**
  - All state is 0.
  - `timer_is_high`=0, `timer_running`=0, `rd_cnt`=0, `timer_irq`=0.
- **States per channel:** IDLE (`running`=0) and RUN (`running`=1).
- **Load** (`set_timer` with N≠0):
  - count=N, reload=N, pre_cnt=0, pre_val=P, periodic latched.
  - Enter RUN; flag is unchanged.
  - Loading a running channel restarts it.
- **Load with N=0:** the channel goes to IDLE with count=0; no flag is set.
- **Tick** in RUN:
  - If pre_cnt==pre_val: tick, and pre_cnt is set to 0.
  - Otherwise pre_cnt increments.
  - On a tick, count decrements.
- **Expiry** is a tick with count==1:
  - flag is set to 1.
  - One-shot: count=0, enter IDLE.
  - Periodic: count=reload, stay in RUN.
- **Stop:** `stop_timer` moves the channel to IDLE; count holds its value; flag is unchanged.
- **Clear:** `clr_flag[ch]` clears the flag.
- **Out-of-range `set_ch`/`rd_ch`** (≥`NUM_CH`):
  - Writes are ignored.
  - `rd_cnt` reads 0.

## Timing
- Load at edge t gives `timer_running`=1 and count=N visible after t.
- Expiry edge is t+N·(P+1).
- Periodic expiries then recur every N·(P+1) cycles.
- **Collisions on the same channel, same cycle:**
  - Load beats stop; stop beats tick.
  - Load beats expiry: no flag is set and the reload uses the new N.
  - Expiry set beats `clr_flag`: the flag remains 1.
- Operations on different channels in the same cycle are independent.
- `set_timer` and `stop_timer` together target only `set_ch`.
- **Count arithmetic** is unsigned CNT_W:
  - count never wraps below 0.
  - N=2^CNT_W−1 is legal.
- An asynchronous reset mid-count returns the channel immediately to the reset values; no flag is set.

## Configuration
- **`MULTI_TIMER_IRQ_EN` defined:**
  - Adds output `timer_irq` and input `irq_mask` (NUM_CH, 1 = enabled).
  - `timer_irq` is registered: the OR of `timer_is_high & irq_mask`, asserted one cycle after the flag is set.
  - It deasserts one cycle after all enabled flags are cleared.
  - Reset value is 0.
- **Not defined:** neither port exists and no IRQ logic is built. Flag behaviour is identical in both cases.

## Test plan
- **One-shot, ch0:** N=5, P=0 at edge 0.
  - `timer_is_high[0]` rises at edge 5; `timer_running[0]` falls at edge 5.
  - `rd_cnt` with `rd_ch`=0 reads 5,4,3,2,1,0.
- **Periodic with prescale, ch1:** N=3, P=1.
  - Flag rises at edge 6.
  - `clr_flag[1]` at edge 8; flag rises again at edge 12.
  - Count reloads to 3 after each expiry.
- **Collision:**
  - Reload ch2 on its expiry edge with N=10: no flag is set, and the next expiry is 10 ticks later.
  - `clr_flag[2]` on an expiry edge: the flag stays 1.
- **Stop and restart:**
  - Stop ch3 at count 4: count holds at 4 for 20 cycles and the flag stays 0.
  - Load N=2: flag at +2.
- **Boundaries:**
  - N=0 load: the channel is idle and the flag stays 0.
  - `set_ch`=NUM_CH: no effect.
  - Assert `rst` low mid-count: all outputs are 0 immediately.
  - Then run all channels concurrently with distinct N and check each expiry independently.
- **`MULTI_TIMER_IRQ_EN`:**
  - `irq_mask`=0b0010 with ch0 and ch1 expiring: `timer_irq` rises 1 cycle after ch1's flag only.
  - Clear ch1: `timer_irq` falls 1 cycle later.
